// File: rtl/permute_pipe.sv
// permute_pipe: two-stage, handshaked N-lane permutation (gather / scatter / pass-through).
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready depends only on out_valid/out_ready)
//   in_mode             00 gather, 01 scatter, 10/11 pass-through
//   in_data             N lanes of W bits, lane k at [k*W +: W]
//   in_sel              N select fields of SELW bits, packed like in_data
//   out_valid/out_ready output handshake
//   out_data            permuted lanes
//   out_err_range       some select field was >= N (gather/scatter only)
//   out_err_conflict    scatter collision among in-range selects
//
// Optional feature: define PERMUTE_CONFLICT_CHECK_EN to generate the scatter
// collision detector; otherwise out_err_conflict is tied low.

`ifndef P
`define P 2
`endif
`ifndef MAP
`define MAP 3
`endif

module permute_pipe #(
    parameter int N    = 2*`P,
    parameter int W    = 16,
    parameter int SELW = `MAP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [N*W-1:0]  in_data,
    input  logic [N*SELW-1:0] in_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_data,
    output logic            out_err_range,
    output logic            out_err_conflict
);

    localparam logic [1:0] MODE_GATHER  = 2'b00;
    localparam logic [1:0] MODE_SCATTER = 2'b01;

    function automatic logic [SELW-1:0] sel_field(input logic [N*SELW-1:0] sel, input int lane);
        return sel[lane*SELW +: SELW];
    endfunction

    // Full-width compare: a field is never truncated before being used as a lane index.
    function automatic logic sel_in_range(input logic [SELW-1:0] s);
        return int'(s) < N;
    endfunction

    function automatic logic sel_hits(input logic [SELW-1:0] s, input int lane);
        return int'(s) == lane;
    endfunction

    logic            stall;
    logic            vld_p1;
    logic [1:0]      mode_p1;
    logic [N*W-1:0]  data_p1;
    logic [N*SELW-1:0] sel_p1;

    logic [N*W-1:0]  map_data_p1;
    logic            map_range_p1;

    // A stall freezes both stages, even when S1 holds a bubble.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---- Stage 1: capture accepted transaction ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall && in_valid) begin
            mode_p1 <= in_mode;
            data_p1 <= in_data;
            sel_p1  <= in_sel;
        end
    end

    // ---- Stage 1 -> 2: crossbar mapping ----
    always_comb begin
        map_data_p1  = '0;
        map_range_p1 = 1'b0;
        case (mode_p1)
            MODE_GATHER: begin
                for (int k = 0; k < N; k++) begin
                    if (!sel_in_range(sel_field(sel_p1, k)))
                        map_range_p1 = 1'b1;
                    for (int j = 0; j < N; j++) begin
                        if (sel_hits(sel_field(sel_p1, k), j))
                            map_data_p1[k*W +: W] = data_p1[j*W +: W];
                    end
                end
            end
            MODE_SCATTER: begin
                // Ascending j so a later (higher) source overwrites an earlier one.
                for (int j = 0; j < N; j++) begin
                    if (!sel_in_range(sel_field(sel_p1, j)))
                        map_range_p1 = 1'b1;
                    for (int k = 0; k < N; k++) begin
                        if (sel_hits(sel_field(sel_p1, j), k))
                            map_data_p1[k*W +: W] = data_p1[j*W +: W];
                    end
                end
            end
            default: begin
                map_data_p1 = data_p1;
            end
        endcase
    end

`ifdef PERMUTE_CONFLICT_CHECK_EN
    logic map_conf_p1;

    // Out-of-range sources never match an in-range one, so they never count.
    always_comb begin
        map_conf_p1 = 1'b0;
        if (mode_p1 == MODE_SCATTER) begin
            for (int j = 1; j < N; j++) begin
                for (int i = 0; i < j; i++) begin
                    if (sel_in_range(sel_field(sel_p1, j)) &&
                        (sel_field(sel_p1, j) == sel_field(sel_p1, i)))
                        map_conf_p1 = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_err_conflict <= 1'b0;
        end else if (!stall && vld_p1) begin
            out_err_conflict <= map_conf_p1;
        end
    end
`else
    assign out_err_conflict = 1'b0;
`endif

    // ---- Stage 2: output register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_err_range <= 1'b0;
        end else if (!stall) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_data      <= map_data_p1;
                out_err_range <= map_range_p1;
            end
        end
    end

endmodule
